// File: rtl/control_decoder.sv
// RV32I main control unit: decodes the major opcode into registered datapath controls.
// One-cycle latency; flush inserts a bubble, stall holds the current control word.
module control_decoder (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [6:0] i_opcode,
  input  logic       i_stall,
  input  logic       i_flush,
  output logic       o_ALUSrc,
  output logic [1:0] o_ALUSrcA,
  output logic       o_MemtoReg,
  output logic       o_RegWrite,
  output logic       o_MemRead,
  output logic       o_MemWrite,
  output logic       o_Branch,
  output logic       o_Jump,
  output logic       o_JALR,
  output logic [1:0] o_ALUOp,
  output logic [2:0] o_ImmSrc,
  output logic       o_Illegal
);

  localparam logic [6:0] OpcR      = 7'b0110011;
  localparam logic [6:0] OpcIAlu   = 7'b0010011;
  localparam logic [6:0] OpcLoad   = 7'b0000011;
  localparam logic [6:0] OpcStore  = 7'b0100011;
  localparam logic [6:0] OpcBranch = 7'b1100011;
  localparam logic [6:0] OpcJal    = 7'b1101111;
  localparam logic [6:0] OpcJalr   = 7'b1100111;
  localparam logic [6:0] OpcAuipc  = 7'b0010111;
  localparam logic [6:0] OpcLui    = 7'b0110111;

  localparam logic [1:0] SrcARs1  = 2'b00;
  localparam logic [1:0] SrcAPc   = 2'b01;
  localparam logic [1:0] SrcAZero = 2'b10;

  localparam logic [1:0] AluAdd   = 2'b00;
  localparam logic [1:0] AluCmp   = 2'b01;
  localparam logic [1:0] AluRFunc = 2'b10;
  localparam logic [1:0] AluIFunc = 2'b11;

  localparam logic [2:0] ImmI = 3'b000;
  localparam logic [2:0] ImmS = 3'b001;
  localparam logic [2:0] ImmB = 3'b010;
  localparam logic [2:0] ImmJ = 3'b011;
  localparam logic [2:0] ImmU = 3'b100;

  typedef struct packed {
    logic       alu_src;
    logic [1:0] alu_src_a;
    logic       mem_to_reg;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic       jump;
    logic       jalr;
    logic [1:0] alu_op;
    logic [2:0] imm_src;
    logic       illegal;
  } ctrl_t;

  localparam ctrl_t CtrlBubble = '0;

  ctrl_t dec;
  ctrl_t ctrl_d, ctrl_q;

  // Unknown or X/Z opcodes fall into default, so only the illegal flag can be raised.
  always_comb begin
    dec = CtrlBubble;
    case (i_opcode)
      OpcR: begin
        dec.reg_write = 1'b1;
        dec.alu_op    = AluRFunc;
        dec.imm_src   = ImmI;
      end
      OpcIAlu: begin
        dec.alu_src   = 1'b1;
        dec.reg_write = 1'b1;
        dec.alu_op    = AluIFunc;
        dec.imm_src   = ImmI;
      end
      OpcLoad: begin
        dec.alu_src    = 1'b1;
        dec.mem_to_reg = 1'b1;
        dec.reg_write  = 1'b1;
        dec.mem_read   = 1'b1;
        dec.alu_op     = AluAdd;
        dec.imm_src    = ImmI;
      end
      OpcStore: begin
        dec.alu_src   = 1'b1;
        dec.mem_write = 1'b1;
        dec.alu_op    = AluAdd;
        dec.imm_src   = ImmS;
      end
      OpcBranch: begin
        dec.branch  = 1'b1;
        dec.alu_op  = AluCmp;
        dec.imm_src = ImmB;
      end
      OpcJal: begin
        dec.reg_write = 1'b1;
        dec.jump      = 1'b1;
        dec.alu_op    = AluAdd;
        dec.imm_src   = ImmJ;
      end
      OpcJalr: begin
        dec.alu_src   = 1'b1;
        dec.reg_write = 1'b1;
        dec.jump      = 1'b1;
        dec.jalr      = 1'b1;
        dec.alu_op    = AluAdd;
        dec.imm_src   = ImmI;
      end
      OpcAuipc: begin
        dec.alu_src   = 1'b1;
        dec.alu_src_a = SrcAPc;
        dec.reg_write = 1'b1;
        dec.alu_op    = AluAdd;
        dec.imm_src   = ImmU;
      end
      OpcLui: begin
        dec.alu_src   = 1'b1;
        dec.alu_src_a = SrcAZero;
        dec.reg_write = 1'b1;
        dec.alu_op    = AluAdd;
        dec.imm_src   = ImmU;
      end
      default: begin
        dec           = CtrlBubble;
        dec.alu_src_a = SrcARs1;
        dec.illegal   = 1'b1;
      end
    endcase
  end

  // Flush wins over stall so a squashed slot never keeps stale side effects.
  always_comb begin
    ctrl_d = ctrl_q;
    if (i_flush) begin
      ctrl_d = CtrlBubble;
    end else if (!i_stall) begin
      ctrl_d = dec;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ctrl_q <= CtrlBubble;
    end else begin
      ctrl_q <= ctrl_d;
    end
  end

  assign o_ALUSrc   = ctrl_q.alu_src;
  assign o_ALUSrcA  = ctrl_q.alu_src_a;
  assign o_MemtoReg = ctrl_q.mem_to_reg;
  assign o_RegWrite = ctrl_q.reg_write;
  assign o_MemRead  = ctrl_q.mem_read;
  assign o_MemWrite = ctrl_q.mem_write;
  assign o_Branch   = ctrl_q.branch;
  assign o_Jump     = ctrl_q.jump;
  assign o_JALR     = ctrl_q.jalr;
  assign o_ALUOp    = ctrl_q.alu_op;
  assign o_ImmSrc   = ctrl_q.imm_src;
  assign o_Illegal  = ctrl_q.illegal;

endmodule

// File: tb/tb_control_decoder.sv
// Scoreboard bench for control_decoder: directed scenarios plus randomized opcodes,
// expected control words computed from instruction-class rules.
module tb_control_decoder;

  logic       clk;
  logic       rst_n;
  logic [6:0] opcode;
  logic       stall;
  logic       flush;
  logic       alu_src;
  logic [1:0] alu_src_a;
  logic       mem_to_reg;
  logic       reg_write;
  logic       mem_read;
  logic       mem_write;
  logic       branch;
  logic       jump;
  logic       jalr;
  logic [1:0] alu_op;
  logic [2:0] imm_src;
  logic       illegal;

  int unsigned n_checks = 0;
  int unsigned n_fails  = 0;

  logic [15:0] sb_q[$];
  logic [15:0] model_state;
  logic [6:0]  legal_ops[9];

  control_decoder dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_opcode   (opcode),
    .i_stall    (stall),
    .i_flush    (flush),
    .o_ALUSrc   (alu_src),
    .o_ALUSrcA  (alu_src_a),
    .o_MemtoReg (mem_to_reg),
    .o_RegWrite (reg_write),
    .o_MemRead  (mem_read),
    .o_MemWrite (mem_write),
    .o_Branch   (branch),
    .o_Jump     (jump),
    .o_JALR     (jalr),
    .o_ALUOp    (alu_op),
    .o_ImmSrc   (imm_src),
    .o_Illegal  (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] dut_word();
    return {alu_src, alu_src_a, mem_to_reg, reg_write, mem_read, mem_write,
            branch, jump, jalr, alu_op, imm_src, illegal};
  endfunction

  // Rule-based reference: each control is derived from which instruction classes need it.
  function automatic logic [15:0] ref_decode(input logic [6:0] op);
    bit is_r, is_i, is_ld, is_st, is_br, is_jal, is_jalr, is_auipc, is_lui, legal;
    logic       e_src, e_mtr, e_rw, e_mr, e_mw, e_br, e_j, e_jr, e_ill;
    logic [1:0] e_srca, e_aop;
    logic [2:0] e_imm;
    is_r     = (op == 7'h33);
    is_i     = (op == 7'h13);
    is_ld    = (op == 7'h03);
    is_st    = (op == 7'h23);
    is_br    = (op == 7'h63);
    is_jal   = (op == 7'h6f);
    is_jalr  = (op == 7'h67);
    is_auipc = (op == 7'h17);
    is_lui   = (op == 7'h37);
    legal    = is_r | is_i | is_ld | is_st | is_br | is_jal | is_jalr | is_auipc | is_lui;
    e_src  = is_i | is_ld | is_st | is_jalr | is_auipc | is_lui;
    e_srca = is_auipc ? 2'd1 : (is_lui ? 2'd2 : 2'd0);
    e_mtr  = is_ld;
    e_rw   = legal & !is_st & !is_br;
    e_mr   = is_ld;
    e_mw   = is_st;
    e_br   = is_br;
    e_j    = is_jal | is_jalr;
    e_jr   = is_jalr;
    e_aop  = is_r ? 2'd2 : (is_i ? 2'd3 : (is_br ? 2'd1 : 2'd0));
    e_imm  = is_st ? 3'd1 : (is_br ? 3'd2 : (is_jal ? 3'd3 : ((is_auipc | is_lui) ? 3'd4 : 3'd0)));
    e_ill  = !legal;
    return {e_src, e_srca, e_mtr, e_rw, e_mr, e_mw, e_br, e_j, e_jr, e_aop, e_imm, e_ill};
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Applies inputs between edges and pushes the word expected after the next rising edge.
  task automatic drive(input logic r, input logic [6:0] op, input logic s, input logic f,
                       input bit chk_async);
    @(negedge clk);
    rst_n  = r;
    opcode = op;
    stall  = s;
    flush  = f;
    if (!r) begin
      model_state = '0;
      if (chk_async) begin
        #1;
        check("async_reset", dut_word(), 16'h0000);
      end
    end else if (f) begin
      model_state = '0;
    end else if (!s) begin
      model_state = ref_decode(op);
    end
    sb_q.push_back(model_state);
  endtask

  // Monitor: every rising edge presents a new control word.
  initial begin
    logic [15:0] exp_w;
    logic [15:0] act_w;
    forever begin
      @(posedge clk);
      #1;
      act_w = dut_word();
      if (sb_q.size() > 0) begin
        exp_w = sb_q.pop_front();
        check("ctrl_word", act_w, exp_w);
      end
      check("memrd_memwr_excl", {15'd0, mem_read & mem_write}, 16'd0);
      check("branch_jump_excl", {15'd0, branch & jump}, 16'd0);
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    legal_ops[0] = 7'h33; legal_ops[1] = 7'h13; legal_ops[2] = 7'h03;
    legal_ops[3] = 7'h23; legal_ops[4] = 7'h63; legal_ops[5] = 7'h6f;
    legal_ops[6] = 7'h67; legal_ops[7] = 7'h17; legal_ops[8] = 7'h37;
    model_state = '0;
    rst_n  = 1'b0;
    opcode = 7'h33;
    stall  = 1'b0;
    flush  = 1'b0;
    #1;
    check("reset_initial", dut_word(), 16'h0000);

    // Reset held with R-type presented, then release.
    repeat (3) drive(1'b0, 7'h33, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 7'h33, 1'b0, 1'b0, 1'b0);

    // Sweep of legal opcodes, one per edge.
    for (int i = 0; i < 9; i++) drive(1'b1, legal_ops[i], 1'b0, 1'b0, 1'b0);

    // Load followed by store.
    drive(1'b1, 7'h03, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 7'h23, 1'b0, 1'b0, 1'b0);

    // Illegal opcodes.
    drive(1'b1, 7'h00, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 7'h7f, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 7'h32, 1'b0, 1'b0, 1'b0);

    // Branch, then stall with R-type presented, then flush during stall.
    drive(1'b1, 7'h63, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 7'h33, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 7'h33, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 7'h33, 1'b1, 1'b1, 1'b0);
    drive(1'b1, 7'h33, 1'b0, 1'b0, 1'b0);

    // JAL decoded, then reset asserted between edges.
    drive(1'b1, 7'h6f, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 7'h6f, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 7'h13, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 7'h13, 1'b0, 1'b0, 1'b0);

    // Randomized traffic with occasional stall, flush and reset.
    for (int i = 0; i < 400; i++) begin
      logic [6:0] op;
      logic       s, f, r;
      if ($urandom_range(0, 9) < 6) op = legal_ops[$urandom_range(0, 8)];
      else op = 7'($urandom);
      s = ($urandom_range(0, 4) == 0);
      f = ($urandom_range(0, 9) == 0);
      r = ($urandom_range(0, 49) != 0);
      drive(r, op, s, f, 1'b0);
    end

    drive(1'b1, 7'h33, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #3;
    check("scoreboard_drained", 16'(sb_q.size()), 16'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
